// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply control path: the 2-bit status
// bus encoding seen by the control unit and the launcher state encoding.
package mm_pkg;

  // Status bus driven towards the control unit.
  localparam logic [1:0] STATUS_IDLE  = 2'b00;
  localparam logic [1:0] STATUS_START = 2'b01;
  localparam logic [1:0] STATUS_RUN   = 2'b10;
  localparam logic [1:0] STATUS_FIN   = 2'b11;

  // Launcher FSM encoding.
  localparam logic [2:0] LS_IDLE   = 3'd0;
  localparam logic [2:0] LS_LAUNCH = 3'd1;
  localparam logic [2:0] LS_RUN    = 3'd2;
  localparam logic [2:0] LS_DONE   = 3'd3;
  localparam logic [2:0] LS_TOUT   = 3'd4;

  // A run is in flight while the status bus is being held or the unit works.
  function automatic logic is_busy_state(input logic [2:0] s);
    return (s == LS_LAUNCH) || (s == LS_RUN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. Clear beats
// increment so a new run always starts from zero.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count register: reset/clear to zero, increment until saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/process_launcher.sv
// Host-side launcher for the matrix-multiply control unit. Raises START on the
// status bus for STATUS_HOLD cycles, then RUNNING until the unit's
// end_process flag is seen or the run length reaches TIMEOUT.
//
// Handshake: go is a level sampled on every edge; it is only acted upon in
// IDLE. A go seen while end_process is still high from the previous run is
// refused with a one-cycle rejected pulse. end_process is a level that stays
// high once set; it is sampled on every edge in LAUNCH and RUN.
module process_launcher
  import mm_pkg::*;
#(
  parameter int unsigned STATUS_HOLD = 2,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             end_process,
  output logic [1:0]       status,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic             rejected,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               HOLD_W   = $clog2(STATUS_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(STATUS_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  TOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        state, state_n;
  logic [1:0]        status_n;
  logic              done_n;
  logic              rejected_n;
  logic              timed_out_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n, hold_inc;
  logic              cnt_clr, cnt_inc;
  logic [CNT_W-1:0]  cnt_next;

  // Cycle counter for the current run.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (cycle_count)
  );

  // Value cycle_count will take at this edge if it counts; used for the
  // timeout test so the abort lands on the edge that reaches TIMEOUT.
  always_comb begin
    cnt_next = (cycle_count == '1) ? cycle_count : cycle_count + CNT_ONE;
    hold_inc = hold_cnt + HOLD_ONE;
  end

  // Next-state and next-output decode; completion is checked before timeout
  // so a flag arriving on the timeout edge still counts as success.
  always_comb begin
    state_n     = state;
    status_n    = status;
    done_n      = 1'b0;
    rejected_n  = 1'b0;
    timed_out_n = timed_out;
    hold_n      = hold_cnt;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      LS_IDLE: begin
        if (go) begin
          if (end_process) begin
            rejected_n = 1'b1;
          end else begin
            state_n     = LS_LAUNCH;
            status_n    = STATUS_START;
            cnt_clr     = 1'b1;
            timed_out_n = 1'b0;
            hold_n      = '0;
          end
        end
      end
      LS_LAUNCH: begin
        cnt_inc = 1'b1;
        hold_n  = hold_inc;
        if (end_process) begin
          state_n  = LS_DONE;
          status_n = STATUS_FIN;
          done_n   = 1'b1;
        end else if (hold_inc == HOLD_END) begin
          state_n  = LS_RUN;
          status_n = STATUS_RUN;
        end
      end
      LS_RUN: begin
        cnt_inc = 1'b1;
        if (end_process) begin
          state_n  = LS_DONE;
          status_n = STATUS_FIN;
          done_n   = 1'b1;
        end else if (cnt_next == TOUT_VAL) begin
          state_n     = LS_TOUT;
          status_n    = STATUS_IDLE;
          timed_out_n = 1'b1;
        end
      end
      LS_DONE: begin
        state_n = LS_IDLE;
      end
      LS_TOUT: begin
        state_n = LS_IDLE;
      end
      default: begin
        state_n  = LS_IDLE;
        status_n = STATUS_IDLE;
      end
    endcase
  end

  // State and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LS_IDLE;
      status    <= STATUS_IDLE;
      done      <= 1'b0;
      rejected  <= 1'b0;
      timed_out <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      status    <= status_n;
      done      <= done_n;
      rejected  <= rejected_n;
      timed_out <= timed_out_n;
      hold_cnt  <= hold_n;
    end
  end

  assign busy = is_busy_state(state);

endmodule
